// File: rtl/fm_buffer_reader_pkg.sv
// Shared constants, FSM state encoding and width helper for the
// feature-map buffer read controller.
package fm_buffer_reader_pkg;

  // Defaults track the FFN input length and the convolution kernel count.
  localparam int unsigned FM_DEPTH_DEF    = 16;
  localparam int unsigned NUM_KERNELS_DEF = 4;

  typedef logic [2:0] fm_state_t;

  localparam fm_state_t ST_IDLE    = 3'd0;
  localparam fm_state_t ST_READ    = 3'd1;
  localparam fm_state_t ST_DRAIN   = 3'd2;
  localparam fm_state_t ST_RELEASE = 3'd3;
  localparam fm_state_t ST_REARM   = 3'd4;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned fm_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/fm_buffer_reader_if.sv
// Control and read-stream signals between the feature-map read controller
// and the write side / matrix-multiply consumer.
interface fm_buffer_reader_if
  import fm_buffer_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = fm_clog2(FM_DEPTH_DEF),
  parameter int unsigned SEL_W  = fm_clog2(NUM_KERNELS_DEF)
) ();

  logic              start;
  logic              hold;
  logic [ADDR_W-1:0] rd_addr;
  logic [SEL_W-1:0]  ram_select;
  logic              rd_valid;
  logic [SEL_W-1:0]  rd_kernel;
  logic              rd_first;
  logic              rd_last;
  logic              busy;
  logic              buffer_release;

  modport master (
    input  start, hold,
    output rd_addr, ram_select, rd_valid, rd_kernel, rd_first, rd_last,
           busy, buffer_release
  );

  modport slave (
    output start, hold,
    input  rd_addr, ram_select, rd_valid, rd_kernel, rd_first, rd_last,
           busy, buffer_release
  );

endinterface

// File: rtl/fm_valid_delay.sv
// Fixed-depth reset-flushed shift register; carries the output tags and
// doubles as a plain delay for the mux select. DEPTH must be at least 1.
module fm_valid_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/fm_buffer_reader.sv
// Sweeps every (address, kernel) pair of the full feature-map buffers and
// emits a tagged sample stream aligned with the registered read-port mux.
module fm_buffer_reader
  import fm_buffer_reader_pkg::*;
#(
  parameter int unsigned FM_DEPTH    = FM_DEPTH_DEF,
  parameter int unsigned NUM_KERNELS = NUM_KERNELS_DEF,
  parameter int unsigned ADDR_W      = fm_clog2(FM_DEPTH),
  parameter int unsigned SEL_W       = fm_clog2(NUM_KERNELS),
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned MUX_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  fm_buffer_reader_if.master bus
);

  localparam int unsigned     TAG_LAT   = RAM_LATENCY + MUX_LATENCY;
  localparam int unsigned     TAG_W     = SEL_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FM_DEPTH - 1);
  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_KERNELS - 1);

  fm_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              release_q, release_d;

  logic              issue;
  logic              issue_first;
  logic              issue_last;
  logic [TAG_W-1:0]  tag_in;
  logic [TAG_W-1:0]  tag_out;

  always_comb begin
    issue       = (state_q == ST_READ) && !bus.hold;
    issue_first = (addr_q == '0) && (sel_q == '0);
    issue_last  = (addr_q == LAST_ADDR) && (sel_q == LAST_SEL);
    tag_in      = issue ? {1'b1, sel_q, issue_first, issue_last} : '0;

    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_READ;
          addr_d  = '0;
          sel_d   = '0;
        end
      end
      ST_READ: begin
        // Counters wrap to zero on the final issue so rd_addr only ever
        // moves on an issue and is already zero for the next sweep.
        if (issue) begin
          if (issue_last) begin
            state_d = ST_DRAIN;
            addr_d  = '0;
            sel_d   = '0;
          end else if (sel_q == LAST_SEL) begin
            sel_d  = '0;
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Last sample on the output means the pipeline empties this edge.
        if (tag_out[TAG_W-1] && tag_out[0]) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_REARM;
      ST_REARM: begin
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    release_d = (state_d == ST_RELEASE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      release_q <= release_d;
    end
  end

  fm_valid_delay #(
    .DEPTH (TAG_LAT),
    .WIDTH (TAG_W)
  ) u_tag_delay (
    .clock (clock),
    .reset (reset),
    .d     (tag_in),
    .q     (tag_out)
  );

  fm_valid_delay #(
    .DEPTH (RAM_LATENCY),
    .WIDTH (SEL_W)
  ) u_sel_delay (
    .clock (clock),
    .reset (reset),
    .d     (sel_q),
    .q     (bus.ram_select)
  );

  assign bus.rd_addr        = addr_q;
  assign bus.rd_valid       = tag_out[TAG_W-1];
  assign bus.rd_kernel      = tag_out[SEL_W+1:2];
  assign bus.rd_first       = tag_out[1];
  assign bus.rd_last        = tag_out[0];
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.buffer_release = release_q;

endmodule

// File: tb/tb_fm_buffer_reader.sv
// Three reader configurations driven in lockstep and compared every cycle
// against a timestamped issue-log model of the sweep.
module tb_fm_buffer_reader;

  localparam int MAXE = 8192;
  localparam int ND   = 3;
  localparam int PH_IDLE = 0, PH_READ = 1, PH_DRAIN = 2, PH_RELEASE = 3, PH_REARM = 4;

  // Config 0: 4x3 lat 1+1, config 1: 1x1 lat 1+1, config 2: 4x3 lat 2+0
  int P_DEP [ND] = '{4, 1, 4};
  int P_NK  [ND] = '{3, 1, 3};
  int P_RL  [ND] = '{1, 1, 2};
  int P_ML  [ND] = '{1, 1, 0};

  logic clk, rst, start, hold;

  fm_buffer_reader_if #(.ADDR_W(2), .SEL_W(2)) if_a ();
  fm_buffer_reader_if #(.ADDR_W(1), .SEL_W(1)) if_b ();
  fm_buffer_reader_if #(.ADDR_W(2), .SEL_W(2)) if_c ();

  assign if_a.start = start;  assign if_a.hold = hold;
  assign if_b.start = start;  assign if_b.hold = hold;
  assign if_c.start = start;  assign if_c.hold = hold;

  fm_buffer_reader #(.FM_DEPTH(4), .NUM_KERNELS(3), .RAM_LATENCY(1), .MUX_LATENCY(1))
    u_dut_a (.clock(clk), .reset(rst), .bus(if_a));
  fm_buffer_reader #(.FM_DEPTH(1), .NUM_KERNELS(1), .RAM_LATENCY(1), .MUX_LATENCY(1))
    u_dut_b (.clock(clk), .reset(rst), .bus(if_b));
  fm_buffer_reader #(.FM_DEPTH(4), .NUM_KERNELS(3), .RAM_LATENCY(2), .MUX_LATENCY(0))
    u_dut_c (.clock(clk), .reset(rst), .bus(if_c));

  logic [3:0] o_addr [ND];
  logic [3:0] o_sel  [ND];
  logic [3:0] o_kern [ND];
  logic       o_valid[ND];
  logic       o_first[ND];
  logic       o_last [ND];
  logic       o_busy [ND];
  logic       o_rel  [ND];

  assign o_addr[0] = 4'(if_a.rd_addr);    assign o_sel[0] = 4'(if_a.ram_select);
  assign o_kern[0] = 4'(if_a.rd_kernel);  assign o_valid[0] = if_a.rd_valid;
  assign o_first[0] = if_a.rd_first;      assign o_last[0] = if_a.rd_last;
  assign o_busy[0] = if_a.busy;           assign o_rel[0] = if_a.buffer_release;
  assign o_addr[1] = 4'(if_b.rd_addr);    assign o_sel[1] = 4'(if_b.ram_select);
  assign o_kern[1] = 4'(if_b.rd_kernel);  assign o_valid[1] = if_b.rd_valid;
  assign o_first[1] = if_b.rd_first;      assign o_last[1] = if_b.rd_last;
  assign o_busy[1] = if_b.busy;           assign o_rel[1] = if_b.buffer_release;
  assign o_addr[2] = 4'(if_c.rd_addr);    assign o_sel[2] = 4'(if_c.ram_select);
  assign o_kern[2] = 4'(if_c.rd_kernel);  assign o_valid[2] = if_c.rd_valid;
  assign o_first[2] = if_c.rd_first;      assign o_last[2] = if_c.rd_last;
  assign o_busy[2] = if_c.busy;           assign o_rel[2] = if_c.buffer_release;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: iss[d][e] = sample index issued at edge e (or -1),
  // selh[d][e] = select counter value presented before edge e.
  int iss   [ND][MAXE];
  int selh  [ND][MAXE];
  int m_phase[ND];
  int m_n    [ND];
  int m_final[ND];
  int edge_n;
  int last_rst;
  int obs_vcnt[ND];
  int obs_rel [ND];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
  endtask

  task automatic model_step(input int d);
    int tot;
    tot = P_DEP[d] * P_NK[d];
    selh[d][edge_n] = (m_phase[d] == PH_READ) ? (m_n[d] % P_NK[d]) : 0;
    iss[d][edge_n]  = -1;
    if (rst) begin
      m_phase[d] = PH_IDLE;
      m_n[d]     = 0;
    end else begin
      case (m_phase[d])
        PH_IDLE: if (start) begin m_phase[d] = PH_READ; m_n[d] = 0; end
        PH_READ: if (!hold) begin
          iss[d][edge_n] = m_n[d];
          m_n[d]++;
          if (m_n[d] == tot) begin m_phase[d] = PH_DRAIN; m_final[d] = edge_n; end
        end
        PH_DRAIN: if (edge_n == m_final[d] + P_RL[d] + P_ML[d]) m_phase[d] = PH_RELEASE;
        PH_RELEASE: m_phase[d] = PH_REARM;
        default: if (!start) m_phase[d] = PH_IDLE;
      endcase
    end
  endtask

  task automatic check_dut(input int d);
    int src, srs, idx, tot;
    logic v;
    tot = P_DEP[d] * P_NK[d];
    src = edge_n - (P_RL[d] + P_ML[d]) + 1;
    srs = edge_n - P_RL[d] + 1;
    idx = (src > last_rst) ? iss[d][src] : -1;
    v   = (idx >= 0);
    check_eq($sformatf("rd_valid[%0d]", d), 32'(o_valid[d]), 32'(v));
    check_eq($sformatf("rd_kernel[%0d]", d), 32'(o_kern[d]), v ? 32'(idx % P_NK[d]) : 32'd0);
    check_eq($sformatf("rd_first[%0d]", d), 32'(o_first[d]), 32'(v && idx == 0));
    check_eq($sformatf("rd_last[%0d]", d), 32'(o_last[d]), 32'(v && idx == tot - 1));
    check_eq($sformatf("rd_addr[%0d]", d), 32'(o_addr[d]),
             (m_phase[d] == PH_READ) ? 32'(m_n[d] / P_NK[d]) : 32'd0);
    check_eq($sformatf("ram_select[%0d]", d), 32'(o_sel[d]),
             (srs > last_rst) ? 32'(selh[d][srs]) : 32'd0);
    check_eq($sformatf("busy[%0d]", d), 32'(o_busy[d]), 32'(m_phase[d] != PH_IDLE));
    check_eq($sformatf("buffer_release[%0d]", d), 32'(o_rel[d]), 32'(m_phase[d] == PH_RELEASE));
    if (o_valid[d] === 1'b1) obs_vcnt[d]++;
    if (o_rel[d] === 1'b1) obs_rel[d]++;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (edge_n >= MAXE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", edge_n, MAXE);
      $fatal(1, "cycle budget exhausted");
    end
    for (int d = 0; d < ND; d++) model_step(d);
    if (rst) last_rst = edge_n;
    #1;
    for (int d = 0; d < ND; d++) check_dut(d);
  endtask

  task automatic clear_obs();
    for (int d = 0; d < ND; d++) begin obs_vcnt[d] = 0; obs_rel[d] = 0; end
  endtask

  task automatic run_until_released(input int budget);
    logic all_done;
    all_done = 1'b0;
    for (int i = 0; i < budget && !all_done; i++) begin
      tick();
      all_done = (obs_rel[0] > 0) && (obs_rel[1] > 0) && (obs_rel[2] > 0);
    end
    check_eq("sweep_released", 32'(all_done), 32'd1);
  endtask

  task automatic check_sweep_counts();
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("sample_count[%0d]", d), 32'(obs_vcnt[d]), 32'(P_DEP[d] * P_NK[d]));
      check_eq($sformatf("release_count[%0d]", d), 32'(obs_rel[d]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    edge_n = 0; last_rst = 0;
    for (int d = 0; d < ND; d++) begin m_phase[d] = PH_IDLE; m_n[d] = 0; m_final[d] = 0; end
    clear_obs();

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Plain sweep, start held high afterwards: must park in REARM.
    start = 1'b1;
    run_until_released(60);
    check_sweep_counts();
    clear_obs();
    repeat (8) tick();
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("rearm_no_sweep[%0d]", d), 32'(obs_vcnt[d] + obs_rel[d]), 32'd0);
      check_eq($sformatf("rearm_busy[%0d]", d), 32'(o_busy[d]), 32'd1);
    end

    // Rearm, then a 3-cycle hold after the fifth issue.
    start = 1'b0;
    repeat (2) tick();
    clear_obs();
    start = 1'b1;
    for (int i = 0; i < 20 && m_n[0] != 5; i++) tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_addr_frozen", 32'(o_addr[0]), 32'd1);
    end
    hold = 1'b0;
    run_until_released(60);
    check_sweep_counts();

    // Reset at the sixth issue, then a clean full sweep.
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    for (int i = 0; i < 20 && m_n[0] != 6; i++) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("reset_valid", 32'(o_valid[0]), 32'd0);
    check_eq("reset_addr", 32'(o_addr[0]), 32'd0);
    clear_obs();
    repeat (6) tick();
    check_eq("post_reset_valid_count", 32'(obs_vcnt[0]), 32'd0);
    check_eq("post_reset_release_count", 32'(obs_rel[0]), 32'd0);
    clear_obs();
    start = 1'b1;
    run_until_released(60);
    check_sweep_counts();

    // Randomised start/hold/reset traffic against the model.
    for (int it = 0; it < 40; it++) begin
      int len;
      start = 1'b0; hold = 1'b0; rst = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
      len = $urandom_range(30, 70);
      for (int c = 0; c < len; c++) begin
        start = ($urandom_range(0, 5) != 0);
        hold  = ($urandom_range(0, 3) == 0);
        rst   = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
